led_fader: RTL

LED_FADER -- requirements
Module: led_fader

---
 rtl/led_fader.sv | 102 ++++++++++
 1 files changed

// File: rtl/led_fader.sv
// Six-channel LED fader: each LED ramps its PWM brightness toward full or off,
// following a synchronized pattern, one level per fade step.
module led_fader #(
    parameter int LVL_BITS = 4,
    parameter int FADE_DIV = 27000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] pattern,
    input  logic       enable,
    input  logic       snap,
    output logic [5:0] leds,
    output logic       busy
);

    localparam int                  NUM_LEDS  = 6;
    localparam logic [LVL_BITS-1:0] MAXL      = '1;
    localparam logic [15:0]         FADE_LAST = 16'(FADE_DIV - 1);

    logic [NUM_LEDS-1:0] pat_meta;
    logic [NUM_LEDS-1:0] pat_s;
    logic [15:0]         fade_cnt;
    logic                fade_tick;
    logic [LVL_BITS-1:0] pwm_cnt;
    logic [LVL_BITS-1:0] level      [NUM_LEDS];
    logic [LVL_BITS-1:0] target     [NUM_LEDS];
    logic [LVL_BITS-1:0] level_next [NUM_LEDS];
    logic [NUM_LEDS-1:0] lit;
    logic [NUM_LEDS-1:0] differs;

    assign fade_tick = (fade_cnt == FADE_LAST);

    // Targets are only ever full-scale or zero, so stepping toward them
    // saturates by construction and can never wrap.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a variable unassigned and no latch is inferred.
        for (int i = 0; i < NUM_LEDS; i++) begin
            target[i]     = pat_s[i] ? MAXL : '0;
            level_next[i] = level[i];
            if (snap) begin
                level_next[i] = target[i];
            end else if (fade_tick && enable) begin
                if (level[i] < target[i]) begin
                    level_next[i] = level[i] + 1'b1;
                end else if (level[i] > target[i]) begin
                    level_next[i] = level[i] - 1'b1;
                end
            end
            differs[i] = (level[i] != target[i]);
            lit[i]     = (level[i] == MAXL) || (pwm_cnt < level[i]);
        end
    end

    // NOTE: all state below uses non-blocking assignments so every flop samples
    // pre-edge values, matching hardware regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_meta <= '0;
            pat_s    <= '0;
        end else begin
            pat_meta <= pattern;
            pat_s    <= pat_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fade_cnt <= '0;
            pwm_cnt  <= '0;
        end else begin
            fade_cnt <= fade_tick ? 16'd0 : fade_cnt + 16'd1;
            pwm_cnt  <= pwm_cnt + 1'b1;
        end
    end

    // NOTE: the level array is reset explicitly; a reset mid-ramp must not
    // leave any brightness behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                level[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LEDS; i++) begin
                level[i] <= level_next[i];
            end
        end
    end

    // Pins are active-low, so reset drives them high (all dark).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            leds <= '1;
            busy <= 1'b0;
        end else begin
            leds <= ~lit;
            busy <= |differs;
        end
    end

endmodule
